// File: rtl/aes_ks_rcon_ctrl_if.sv
// Handshake and strobe bundle of the AES-128 key-schedule sequencer.
// master: the sequencer; slave: datapath / round-constant generator / host side.
// Optional macro AES_KS_RND_STALL_EN adds rnd_valid and pipe_en.
interface aes_ks_rcon_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       key_load;
    logic       sbox_valid;
    logic       key_update;
    logic       rcon_init;
    logic       rcon_update;
    logic       rcon_gate;
    logic [3:0] round;
    logic       out_valid;
    logic       out_ready;
`ifdef AES_KS_RND_STALL_EN
    logic       rnd_valid;
    logic       pipe_en;

    modport master (
        input  in_valid, out_ready, rnd_valid,
        output in_ready, key_load, sbox_valid, key_update,
               rcon_init, rcon_update, rcon_gate, round, out_valid, pipe_en
    );
    modport slave (
        output in_valid, out_ready, rnd_valid,
        input  in_ready, key_load, sbox_valid, key_update,
               rcon_init, rcon_update, rcon_gate, round, out_valid, pipe_en
    );
`else
    modport master (
        input  in_valid, out_ready,
        output in_ready, key_load, sbox_valid, key_update,
               rcon_init, rcon_update, rcon_gate, round, out_valid
    );
    modport slave (
        output in_valid, out_ready,
        input  in_ready, key_load, sbox_valid, key_update,
               rcon_init, rcon_update, rcon_gate, round, out_valid
    );
`endif
endinterface

// File: rtl/aes_ks_rcon_ctrl.sv
// Sequencing FSM for the masked AES-128 key schedule: issues SubWord to the
// shared S-box, waits SBOX_LAT cycles, then mixes the word update with the
// gated round constant. Owns the round counter and start/done handshake.
// Optional macro AES_KS_RND_STALL_EN: rnd_valid stalls SUB/WAIT/XOR, pipe_en
// freezes the S-box pipeline in step.
module aes_ks_rcon_ctrl #(
    parameter int unsigned SBOX_LAT = 4,
    parameter int unsigned NROUNDS  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_ks_rcon_ctrl_if.master      bus
);
    localparam logic [3:0] LAT_M1     = 4'(SBOX_LAT - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SUB, S_WAIT, S_XOR, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] round_q, round_d;

    logic in_ready, key_load, sbox_valid, key_update;
    logic rcon_init, rcon_update, rcon_gate, out_valid, pipe_en;
    logic adv;

`ifdef AES_KS_RND_STALL_EN
    assign adv = bus.rnd_valid;
    assign bus.pipe_en = pipe_en;
`else
    assign adv = 1'b1;
`endif

    // State, wait counter and round counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

    // Next-state and strobe decode; reset overrides outputs so an abort
    // never leaks a partial strobe in the reset cycle itself.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        round_d     = round_q;
        in_ready    = 1'b0;
        key_load    = 1'b0;
        sbox_valid  = 1'b0;
        key_update  = 1'b0;
        rcon_init   = 1'b0;
        rcon_update = 1'b0;
        rcon_gate   = 1'b0;
        out_valid   = 1'b0;
        pipe_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Generator is held at 0x01 for as long as we sit idle.
                in_ready  = 1'b1;
                rcon_init = 1'b1;
                if (bus.in_valid) begin
                    key_load = 1'b1;
                    round_d  = '0;
                    state_d  = S_SUB;
                end
            end
            S_SUB: begin
                pipe_en = adv;
                if (adv) begin
                    sbox_valid = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                pipe_en = adv;
                if (adv) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAT_M1) begin
                        state_d = S_XOR;
                    end
                end
            end
            S_XOR: begin
                pipe_en = adv;
                if (adv) begin
                    key_update  = 1'b1;
                    rcon_gate   = 1'b1;
                    rcon_update = 1'b1;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_SUB;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            in_ready    = 1'b1;
            key_load    = 1'b0;
            sbox_valid  = 1'b0;
            key_update  = 1'b0;
            rcon_init   = 1'b1;
            rcon_update = 1'b0;
            rcon_gate   = 1'b0;
            out_valid   = 1'b0;
            pipe_en     = 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.key_load    = key_load;
    assign bus.sbox_valid  = sbox_valid;
    assign bus.key_update  = key_update;
    assign bus.rcon_init   = rcon_init;
    assign bus.rcon_update = rcon_update;
    assign bus.rcon_gate   = rcon_gate;
    assign bus.out_valid   = out_valid;
    assign bus.round       = rst ? 4'd0 : round_q;
endmodule

// File: tb/tb_aes_ks_rcon_ctrl.sv
// Bench for aes_ks_rcon_ctrl: two instances (SBOX_LAT=4/NROUNDS=10 and
// SBOX_LAT=1/NROUNDS=1) with a round-constant generator attached to each.
// Expected behaviour per cycle comes from the cycle arithmetic of a run
// (offset from accept, round period SBOX_LAT+2), not from any state machine.
module tb_aes_ks_rcon_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_ks_rcon_ctrl_if if_a ();
    aes_ks_rcon_ctrl_if if_b ();

    aes_ks_rcon_ctrl #(.SBOX_LAT(4), .NROUNDS(10)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.master)
    );
    aes_ks_rcon_ctrl #(.SBOX_LAT(1), .NROUNDS(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int last_round [2];

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Round-constant generator attached to each sequencer.
    logic [7:0] rcon_a, rcon_b, gated_a, gated_b;
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction
    always @(posedge clk) begin
        if (if_a.rcon_init) rcon_a <= 8'h01;
        else if (if_a.rcon_update) rcon_a <= xt(rcon_a);
        if (if_b.rcon_init) rcon_b <= 8'h01;
        else if (if_b.rcon_update) rcon_b <= xt(rcon_b);
    end
    assign gated_a = if_a.rcon_gate ? rcon_a : 8'h00;
    assign gated_b = if_b.rcon_gate ? rcon_b : 8'h00;

    function automatic logic [15:0] pack(input logic ir, kl, sv, ku, ri, ru, rg, ov,
                                         input logic [3:0] rnd);
        return {4'h0, ir, kl, sv, ku, ri, ru, rg, ov, rnd};
    endfunction

    function automatic logic [15:0] get_out(input int sel);
        if (sel == 0)
            return pack(if_a.in_ready, if_a.key_load, if_a.sbox_valid, if_a.key_update,
                        if_a.rcon_init, if_a.rcon_update, if_a.rcon_gate, if_a.out_valid, if_a.round);
        return pack(if_b.in_ready, if_b.key_load, if_b.sbox_valid, if_b.key_update,
                    if_b.rcon_init, if_b.rcon_update, if_b.rcon_gate, if_b.out_valid, if_b.round);
    endfunction

    function automatic logic [7:0] get_gated(input int sel);
        return (sel == 0) ? gated_a : gated_b;
    endfunction

`ifdef AES_KS_RND_STALL_EN
    function automatic logic get_pipe(input int sel);
        return (sel == 0) ? if_a.pipe_en : if_b.pipe_en;
    endfunction
`endif

    task automatic set_in(input int sel, input logic iv, input logic ordy, input logic rv);
        if (sel == 0) begin
            if_a.in_valid  = iv;
            if_a.out_ready = ordy;
`ifdef AES_KS_RND_STALL_EN
            if_a.rnd_valid = rv;
`endif
        end else begin
            if_b.in_valid  = iv;
            if_b.out_ready = ordy;
`ifdef AES_KS_RND_STALL_EN
            if_b.rnd_valid = rv;
`endif
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete run on instance sel, cycle 0 = accept cycle.
    // abort_at > 0 asserts rst in that cycle and ends the run there.
    task automatic run(input int sel, input int rdy_dly, input bit noise,
                       input int st_at, input int st_len, input int abort_at,
                       output int first_valid, output int n_upd);
        int lat, nr, per, t_done, ce, o, p, r;
        bit stalled, ku, sv, ordy, done;
        logic [15:0] exp;
        logic [7:0]  exp_g;
        lat = (sel == 0) ? 4 : 1;
        nr  = (sel == 0) ? 10 : 1;
        per = lat + 2;
        t_done = nr * per + 1;
        first_valid = -1;
        n_upd = 0;
        done = 1'b0;

        set_in(sel, 1'b1, 1'b0, 1'b1);
        #4;
        chk("accept", get_out(sel), pack(1, 1, 0, 0, 1, 0, 0, 0, 4'(last_round[sel])));
        chk("accept_rcon", {8'h00, get_gated(sel)}, 16'h0);
`ifdef AES_KS_RND_STALL_EN
        chk("accept_pipe_en", {15'h0, get_pipe(sel)}, 16'h0);
`endif
        @(posedge clk); #1;

        for (int c = 1; c < t_done + st_len + rdy_dly + 8; c++) begin
            if (c == abort_at) begin
                rst = 1'b1;
                set_in(sel, 1'b1, 1'b0, 1'b1);
                #4;
                chk("reset_out", get_out(sel), pack(1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
                @(posedge clk); #1;
                rst = 1'b0;
                set_in(sel, 1'b0, 1'b0, 1'b1);
                #4;
                chk("post_reset", get_out(sel), pack(1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
                last_round[0] = 0;
                last_round[1] = 0;
                @(posedge clk); #1;
                return;
            end
            stalled = (st_len > 0) && (c >= st_at) && (c < st_at + st_len);
            ce = c - (c < st_at ? 0 : ((c - st_at) > st_len ? st_len : (c - st_at)));
            ordy = (ce >= t_done + rdy_dly);
            set_in(sel, noise ? 1'($urandom_range(0, 1)) : 1'b0, ordy, !stalled);
            #4;
            if (ce >= t_done) begin
                exp   = pack(0, 0, 0, 0, 0, 0, 0, 1, 4'(nr - 1));
                exp_g = 8'h00;
            end else begin
                o  = ce - 1;
                p  = o % per;
                r  = o / per;
                sv = !stalled && (p == 0);
                ku = !stalled && (p == per - 1);
                exp   = pack(0, 0, sv, ku, 0, ku, ku, 0, 4'(r));
                exp_g = ku ? rcon_tab[r] : 8'h00;
            end
            chk("cycle", get_out(sel), exp);
            chk("rcon_gated", {8'h00, get_gated(sel)}, {8'h00, exp_g});
`ifdef AES_KS_RND_STALL_EN
            chk("pipe_en", {15'h0, get_pipe(sel)}, {15'h0, (ce < t_done) && !stalled});
`endif
            if (get_out(sel)[4] && first_valid < 0) first_valid = c;
            if (get_out(sel)[8]) n_upd++;
            @(posedge clk); #1;
            if (ordy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: run on dut %0d did not complete", sel);
        end

        set_in(sel, 1'b0, 1'b0, 1'b1);
        #4;
        chk("idle", get_out(sel), pack(1, 0, 0, 0, 1, 0, 0, 0, 4'(nr - 1)));
        last_round[sel] = nr - 1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int sel;
        int rdy;
        bit noise;
        int st_at;
        int st_len;
        int exp_fv;
        int exp_upd;
    } vec_t;

    initial begin
        vec_t tab [$];
        int fv, nu;

        tab.push_back('{0, 0, 1'b0, 0, 0, 61, 10});
        tab.push_back('{0, 5, 1'b1, 0, 0, 61, 10});
        tab.push_back('{1, 0, 1'b0, 0, 0, 4, 1});
        tab.push_back('{1, 3, 1'b1, 0, 0, 4, 1});
`ifdef AES_KS_RND_STALL_EN
        tab.push_back('{0, 0, 1'b0, 2, 3, 64, 10});
`endif

        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b1);
        set_in(1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        #4;
        chk("reset_a", get_out(0), pack(1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
        chk("reset_b", get_out(1), pack(1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        chk("idle_a", get_out(0), pack(1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
        chk("idle_b", get_out(1), pack(1, 0, 0, 0, 1, 0, 0, 0, 4'd0));
        last_round[0] = 0;
        last_round[1] = 0;
        @(posedge clk); #1;

        foreach (tab[i]) begin
            run(tab[i].sel, tab[i].rdy, tab[i].noise, tab[i].st_at, tab[i].st_len, 0, fv, nu);
            chk("first_out_valid", 16'(fv), 16'(tab[i].exp_fv));
            chk("key_update_count", 16'(nu), 16'(tab[i].exp_upd));
        end

        // Abort in WAIT of round 3, then a clean restart must begin at rcon 01.
        run(0, 0, 1'b0, 0, 0, 21, fv, nu);
        run(0, 1, 1'b0, 0, 0, 0, fv, nu);
        chk("restart_first_valid", 16'(fv), 16'd61);

        // Randomized runs against the cycle-arithmetic model.
        for (int k = 0; k < 6; k++) begin
            int sel, rdy, lat, nr, sa, sl;
            sel = int'($urandom_range(0, 1));
            rdy = int'($urandom_range(0, 6));
            lat = (sel == 0) ? 4 : 1;
            nr  = (sel == 0) ? 10 : 1;
            sa  = 0;
            sl  = 0;
`ifdef AES_KS_RND_STALL_EN
            sa = int'($urandom_range(1, nr * (lat + 2)));
            sl = int'($urandom_range(0, 4));
`endif
            run(sel, rdy, 1'b1, sa, sl, 0, fv, nu);
            chk("rand_first_valid", 16'(fv), 16'(nr * (lat + 2) + 1 + sl));
            chk("rand_update_count", 16'(nu), 16'(nr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_ks_rcon_ctrl.md
Name: aes_ks_rcon_ctrl

Overview:
- Sequencing FSM for the masked AES-128 key schedule; sits directly upstream of the round-constant generator.
- Drives the generator's reset, advance and gate inputs, plus the key-schedule datapath strobes (SubWord issue, word-update).
- Owns the round counter and the start/done handshake of the key-schedule unit.
- Shared S-box latency is a parameter; the FSM waits for it explicitly.

Parameters:
SBOX_LAT, 4, pipeline latency of the shared masked S-box in cycles; legal 1..15
NROUNDS, 10, number of round keys produced; legal 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  start request, key shares present on datapath
in_ready  out  1  high only in IDLE
key_load  out  1  one-cycle pulse: datapath captures key shares
sbox_valid  out  1  one-cycle pulse: last key column issued to S-box
key_update  out  1  one-cycle pulse: datapath XORs S-box output into the four words
rcon_init  out  1  to generator reset: reload rcon = 0x01
rcon_update  out  1  to generator update: advance rcon after current use
rcon_gate  out  1  to generator gate: high passes rcon, low forces 0
round  out  4  current round index 0..NROUNDS-1
out_valid  out  1  key schedule complete, final round key stable
out_ready  in  1  consumer acknowledge

Behaviour:
- States: IDLE, SUB, WAIT, XOR, DONE; state register plus 4-bit wait counter and 4-bit round counter.
- Reset (rst=1): state forced to IDLE, round=0, wait counter=0, rcon_init=1. All other outputs 0 except in_ready=1. Reset mid-operation aborts immediately; no partial strobes.
- IDLE: in_ready=1. On in_valid=1:
  - key_load=1 and rcon_init=1 in the same cycle
  - round<=0, next state SUB.
- SUB: sbox_valid=1 for exactly one cycle; wait counter<=0; next state WAIT.
- WAIT: counter increments each cycle; when counter==SBOX_LAT-1 go to XOR. Occupies exactly SBOX_LAT cycles (SBOX_LAT=1 gives one cycle).
- XOR: key_update=1, rcon_gate=1, rcon_update=1, all in the same cycle.
  - The generator presents the value for this round during this cycle and advances at the following edge.
  - If round==NROUNDS-1: go to DONE, round held. Otherwise round<=round+1 and go to SUB.
- rcon_gate is 0 in every state except XOR, so the generator output is zero outside key mixing.
- DONE: out_valid=1 until the cycle where out_ready=1; then go to IDLE. out_valid is not dropped without out_ready.
- in_valid outside IDLE is ignored; in_ready=0 there.
- Latency: accept at cycle 0, first sbox_valid at cycle 1. Each round takes SBOX_LAT+2 cycles. out_valid first high at cycle NROUNDS*(SBOX_LAT+2)+1; this is 61 for the defaults.
- Exactly NROUNDS pulses each of sbox_valid, key_update and rcon_update per run, and exactly one key_load.

Optional Feature:
- Macro AES_KS_RND_STALL_EN.
- Defined:
  - Adds input rnd_valid (1 bit) and output pipe_en (1 bit).
  - In SUB, WAIT and XOR the FSM advances only when rnd_valid=1. When rnd_valid=0 the state, counters and all strobes are held low (sbox_valid, key_update, rcon_update, rcon_gate=0) and the cycle is repeated.
  - pipe_en = rnd_valid in SUB/WAIT/XOR and 0 elsewhere; it freezes the S-box pipeline in step with the FSM.
  - IDLE and DONE are unaffected by rnd_valid.
- Undefined: no extra ports; behaviour as above, equivalent to rnd_valid tied to 1.

Test Plan:
- Reset then single run, SBOX_LAT=4, NROUNDS=10, out_ready=1 -> in_ready at cycle 0 only; out_valid at cycle 61; 10 key_update pulses at cycles 6,12,...,60; round reads 0..9.
- Generator attached, sample gated rcon at each key_update -> 01,02,04,08,10,20,40,80,1b,36; gated output 00 in all other cycles.
- out_ready held 0 for 5 cycles in DONE -> out_valid stays 1 for 5 cycles; in_valid ignored; IDLE is reached on the first cycle out_ready=1.
- rst asserted in WAIT of round 3 -> next cycle IDLE, rcon_init=1, round=0; a new start then gives rcon 01 at the first key_update.
- SBOX_LAT=1, NROUNDS=1 -> sbox_valid at cycle 1, key_update at cycle 3, out_valid at cycle 4.
- AES_KS_RND_STALL_EN defined, rnd_valid=0 for 3 cycles during round 0 WAIT -> all strobes and pipe_en 0 during the stall; out_valid at cycle 64.
